// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, lane-vector type and output saturation for the fully-connected neuron MAC.
package fc_pkg;
   localparam int LANES = 128;
   localparam int BEATS = 4;
   localparam int DATA_W = 32;
   localparam int FRAC = 16;
   localparam int PROD_W = 48;
   localparam int TREE_DEPTH = 7;
   localparam int SUM_W = PROD_W + TREE_DEPTH;
   localparam int ACC_W = 58;
   typedef logic [LANES*DATA_W-1:0] lane_vec_t;
   typedef struct packed {
      logic ovf;
      logic [DATA_W-1:0] value;
   } sat_t;
   // In range exactly when every bit above the 32-bit sign bit matches it.
   function automatic sat_t saturate(input logic signed [ACC_W-1:0] a);
      logic [ACC_W-DATA_W:0] top;
      sat_t s;
      top = a[ACC_W-1:DATA_W-1];
      s.ovf = !(&top || !(|top));
      s.value = s.ovf ? {a[ACC_W-1], {(DATA_W-1){!a[ACC_W-1]}}} : a[DATA_W-1:0];
      return s;
   endfunction
endpackage

// File: rtl/fc_add_tree.sv
// fc_add_tree: pipelined binary reduction of the lane products, one register per level;
// valid/beat/bias tags travel alongside so the accumulator sees them aligned with the sum.
module fc_add_tree
   import fc_pkg::*;
#(
   parameter int LANES = fc_pkg::LANES,
   parameter int BW = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid,
   input  logic [BW-1:0]            beat,
   input  logic [DATA_W-1:0]        bias,
   input  logic signed [PROD_W-1:0] prod [LANES],
   output logic                     sum_valid,
   output logic [BW-1:0]            sum_beat,
   output logic [DATA_W-1:0]        sum_bias,
   output logic signed [SUM_W-1:0]  sum
);
   localparam int N = 1 << TREE_DEPTH;
   for (genvar l = 0; l <= TREE_DEPTH; l++) begin : lv
      logic signed [SUM_W-1:0] s [N >> l];
      logic v;
      logic [BW-1:0] b;
      logic [DATA_W-1:0] c;
      if (l == 0) begin : g
         // Lanes beyond LANES pad the tree with zeros.
         always_comb
            for (int i = 0; i < N; i++) s[i] = i < LANES ? SUM_W'(prod[i]) : '0;
         assign v = valid;
         assign b = beat;
         assign c = bias;
      end else begin : g
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) v <= 1'b0;
            else v <= lv[l-1].v;
         always_ff @(posedge clk)
            if (lv[l-1].v) begin
               b <= lv[l-1].b;
               c <= lv[l-1].c;
               for (int i = 0; i < (N >> l); i++) s[i] <= lv[l-1].s[2*i] + lv[l-1].s[2*i+1];
            end
      end
   end
   assign sum_valid = lv[TREE_DEPTH].v;
   assign sum_beat = lv[TREE_DEPTH].b;
   assign sum_bias = lv[TREE_DEPTH].c;
   assign sum = lv[TREE_DEPTH].s[0];
endmodule

// File: rtl/fc_neuron_mac.sv
// fc_neuron_mac: Q16.16 dot product of a LANES*BEATS vector plus bias, 9-edge latency, full rate.
// Define FC_RELU_EN to clamp negative saturated results to zero.
module fc_neuron_mac
   import fc_pkg::*;
#(
   parameter int LANES = fc_pkg::LANES,
   parameter int BEATS = fc_pkg::BEATS,
   parameter int FRAC = fc_pkg::FRAC
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [LANES*DATA_W-1:0] data_in,
   input  logic [LANES*DATA_W-1:0] weight_in,
   input  logic [DATA_W-1:0]       bias_in,
   output logic                    valid_out,
   output logic [DATA_W-1:0]       data_out,
   output logic                    ovf
);
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   logic [BW-1:0] beat_cnt, p_beat, s_beat;
   logic p_valid, s_valid, acc_last;
   logic [DATA_W-1:0] p_bias, s_bias;
   logic signed [PROD_W-1:0] prod [LANES];
   logic signed [SUM_W-1:0] sum;
   logic signed [ACC_W-1:0] acc;
   sat_t res;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         beat_cnt <= '0;
         p_valid <= 1'b0;
      end else begin
         p_valid <= valid_in;
         if (valid_in) beat_cnt <= beat_cnt == BW'(BEATS-1) ? '0 : beat_cnt + 1'b1;
      end
   // Full 64-bit product, floor-shifted back to Q16.16 and kept 48 bits wide.
   always_ff @(posedge clk)
      if (valid_in) begin
         p_beat <= beat_cnt;
         p_bias <= bias_in;
         for (int k = 0; k < LANES; k++)
            prod[k] <= PROD_W'((64'($signed(data_in[k*DATA_W +: DATA_W])) *
                                64'($signed(weight_in[k*DATA_W +: DATA_W]))) >>> FRAC);
      end
   fc_add_tree #(.LANES(LANES), .BW(BW)) u_tree (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (p_valid),
      .beat      (p_beat),
      .bias      (p_bias),
      .prod      (prod),
      .sum_valid (s_valid),
      .sum_beat  (s_beat),
      .sum_bias  (s_bias),
      .sum       (sum)
   );
   always_comb begin
      res = saturate(acc);
`ifdef FC_RELU_EN
      res.value = res.value[DATA_W-1] ? '0 : res.value;
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         acc_last <= 1'b0;
         valid_out <= 1'b0;
         data_out <= '0;
         ovf <= 1'b0;
      end else begin
         acc_last <= s_valid && s_beat == BW'(BEATS-1);
         if (s_valid) acc <= (s_beat == '0 ? ACC_W'($signed(s_bias)) : acc) + ACC_W'(sum);
         valid_out <= acc_last;
         if (acc_last) begin
            data_out <= res.value;
            ovf <= res.ovf;
         end
      end
endmodule

// File: tb/tb_fc_neuron_mac.sv
// tb_fc_neuron_mac: directed and randomized vectors checked against a dot-product reference model.
module tb_fc_neuron_mac;
   import fc_pkg::*;
   localparam int L = 128;
   localparam int B = 4;
   typedef struct {
      logic [31:0] v;
      logic o;
      int edge_n;
   } exp_t;
   logic clk = 0, rst_n = 0, valid_in = 0;
   lane_vec_t data_in = '0, weight_in = '0;
   logic [31:0] bias_in = '0;
   logic valid_out, ovf;
   logic [31:0] data_out;
   int n_chk = 0, n_fail = 0, cyc = 0, outs = 0, beat_m = 0, n0, g, m;
   longint acc_m;
   exp_t q[$];
   exp_t e;
   logic [31:0] last_out;
   logic last_ovf;

   fc_neuron_mac #(.LANES(L), .BEATS(B), .FRAC(16)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .weight_in(weight_in),
      .bias_in(bias_in), .valid_out(valid_out), .data_out(data_out), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t sat_model(input longint a);
      exp_t r;
      longint mx = 2147483647;
      r.o = a > mx || a < -mx - 1;
      r.v = a > mx ? 32'h7FFFFFFF : a < -mx - 1 ? 32'h80000000 : a[31:0];
`ifdef FC_RELU_EN
      if (r.v[31]) r.v = '0;
`endif
      r.edge_n = 0;
      return r;
   endfunction

   always @(negedge clk)
      if (!rst_n) begin
         last_out = '0;
         last_ovf = 1'b0;
      end else if (valid_out) begin
         outs++;
         if (q.size() == 0) chk("unexpected valid_out", 1, 0);
         else begin
            e = q.pop_front();
            chk("data_out", data_out, e.v);
            chk("ovf", ovf, e.o);
            chk("latency edge", cyc, e.edge_n);
         end
         last_out = data_out;
         last_ovf = ovf;
      end else begin
         chk("hold data_out", data_out, last_out);
         chk("hold ovf", ovf, last_ovf);
      end

   // mode 0: constants on every lane, 1: small random, 2: full-range random
   task automatic beat(input int mode, input logic [31:0] dc, input logic [31:0] wc, input logic [31:0] bc);
      longint dot = 0;
      logic [31:0] d, w;
      exp_t r;
      @(negedge clk);
      for (int k = 0; k < L; k++) begin
         d = mode == 2 ? $urandom : mode == 1 ? 32'($urandom_range(0, 262144)) - 32'd131072 : dc;
         w = mode == 2 ? $urandom : mode == 1 ? 32'($urandom_range(0, 262144)) - 32'd131072 : wc;
         data_in[32*k +: 32] = d;
         weight_in[32*k +: 32] = w;
         dot += (longint'(signed'(d)) * longint'(signed'(w))) >>> 16;
      end
      bias_in = mode > 0 ? 32'($urandom_range(0, 32'h01000000)) - 32'h00800000 : bc;
      valid_in = 1'b1;
      acc_m = beat_m == 0 ? dot + longint'(signed'(bias_in)) : acc_m + dot;
      if (beat_m == B - 1) begin
         r = sat_model(acc_m);
         r.edge_n = cyc + 10;
         q.push_back(r);
      end
      beat_m = (beat_m + 1) % B;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      valid_in = 1'b0;
      q.delete();
      beat_m = 0;
      #1;
      chk("reset valid_out", valid_out, 0);
      chk("reset data_out", data_out, 0);
      chk("reset ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic wait_n(input int target, input string nm);
      for (int i = 0; i < 40 && outs < target; i++) @(posedge clk);
      if (outs < target) chk({nm, " timeout"}, outs, target);
   endtask

   task automatic vec(input logic [31:0] dc, input logic [31:0] wc, input logic [31:0] bc, input int gap,
                      input logic [31:0] ev, input logic eo, input string nm);
      int s0 = outs;
      for (int b = 0; b < B; b++) begin
         beat(0, dc, wc, bc);
         if (gap > 0 && b < B - 1) idle(gap);
      end
      chk({nm, " model"}, q[q.size()-1].v, ev);
      idle(1);
      wait_n(s0 + 1, nm);
      chk({nm, " data_out"}, last_out, ev);
      chk({nm, " ovf"}, last_ovf, eo);
      repeat (12) @(posedge clk);
      chk({nm, " pulses"}, outs - s0, 1);
   endtask

   initial begin
      do_reset();
      vec(32'h00010000, 32'h00010000, 0, 0, 32'h02000000, 0, "unit");
`ifdef FC_RELU_EN
      vec(32'h00010000, 32'hFFFF0000, 0, 0, 32'h00000000, 0, "negative");
`else
      vec(32'h00010000, 32'hFFFF0000, 0, 0, 32'hFE000000, 0, "negative");
`endif
      vec(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 32'h7FFFFFFF, 1, "saturate");
      vec(32'h00010000, 32'h00010000, 32'h00008000, 3, 32'h02008000, 0, "gapped bias");
      for (int b = 0; b < 3; b++) beat(0, 32'h00010000, 32'h00010000, 0);
      do_reset();
      vec(32'h00010000, 32'h00010000, 0, 0, 32'h02000000, 0, "after reset");
      n0 = outs;
      for (int b = 0; b < B; b++) beat(0, 32'h00010000, 32'h00010000, 0);
      chk("b2b model A", q[q.size()-1].v, 32'h02000000);
      for (int b = 0; b < B; b++) beat(0, 32'h00010000, 32'h00020000, 0);
      chk("b2b model B", q[q.size()-1].v, 32'h04000000);
      idle(1);
      wait_n(n0 + 2, "b2b");
      chk("b2b data_out", last_out, 32'h04000000);
      repeat (12) @(posedge clk);
      chk("b2b pulses", outs - n0, 2);
      for (int n = 0; n < 40; n++) begin
         g = $urandom_range(0, 3);
         m = $urandom_range(1, 2);
         for (int b = 0; b < B; b++) begin
            beat(m, 0, 0, 0);
            if (g == 3 && b == 1) idle($urandom_range(1, 4));
            if (n == 20 && b == 2) do_reset();
         end
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);
      for (int i = 0; i < 60 && q.size() > 0; i++) @(posedge clk);
      chk("drain", q.size(), 0);
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fc_neuron_mac.md
FC_NEURON_MAC -- requirements
Module: fc_neuron_mac

Interface
REQ-001 SHALL have parameter LANES, default 128, number of parallel lanes per beat.
REQ-002 SHALL have parameter BEATS, default 4, beats per input vector (LANES*BEATS = 512 elements).
REQ-003 SHALL have parameter FRAC, default 16, fraction bits of the signed Q16.16 data format.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1, qualifies one beat.
REQ-007 SHALL have port data_in, input, LANES*32, activations; lane k occupies bits [32k+31:32k].
REQ-008 SHALL have port weight_in, input, LANES*32, weights, lane-aligned with data_in.
REQ-009 SHALL have port bias_in, input, 32, neuron bias, sampled only with beat 0.
REQ-010 SHALL have port valid_out, output, 1, one-cycle pulse per completed vector.
REQ-011 SHALL have port data_out, output, 32, Q16.16 neuron result.
REQ-012 SHALL have port ovf, output, 1, saturation occurred; valid only with valid_out.

Function
REQ-013 SHALL take beat index from an internal counter 0..BEATS-1, advanced on each valid_in and wrapping to 0 after BEATS-1; idle gaps between beats allowed, no backpressure.
REQ-014 SHALL form per-lane product as the 64-bit signed product arithmetic-shifted right by FRAC (truncation toward -inf), kept 48 bits wide, registered at the edge sampling the beat.
REQ-015 SHALL reduce the LANES products through a 7-level binary adder tree, one register per level, with 1 guard bit per level (55-bit sum).
REQ-016 SHALL carry valid, beat index, and (for beat 0) bias alongside the data through every pipeline stage.
REQ-017 SHALL, in the accumulate stage, load the accumulator (58-bit signed) with sum + sign-extended bias on beat 0 and add sum on beats 1..BEATS-1.
REQ-018 SHALL, one edge after the beat BEATS-1 accumulate, register data_out saturated to [0x80000000, 0x7FFFFFFF], set ovf if clipped, pulse valid_out high for one cycle.
REQ-019 SHALL give latency 9 edges: valid_out rises at the 9th edge after the edge sampling beat BEATS-1.
REQ-020 SHALL accept back-to-back vectors at full rate (one beat per cycle), with no bubble and no cross-vector contamination.
REQ-021 SHALL hold data_out and ovf stable between valid_out pulses.

Reset
REQ-022 SHALL on rst_n low clear beat counter, all pipeline valid tags, accumulator, valid_out, data_out, ovf to 0; partial vectors in flight are discarded and produce no valid_out.
REQ-023 SHALL treat the first valid_in after reset release as beat 0.

Configuration
REQ-024 SHALL with macro FC_RELU_EN defined apply ReLU after saturation (negative results become 0x00000000, ovf unaffected by ReLU); without it output the signed saturated value.

Structure
REQ-025 SHALL place LANES, BEATS, data width 32, FRAC, product width 48, tree depth 7, accumulator width 58 and a lane-vector typedef in shared package fc_pkg.
REQ-026 SHALL implement the pipelined reduction as sub-module fc_add_tree (carries valid/beat/bias tags), instantiated once.

Verification
REQ-027 SHALL cover: all data 0x00010000, all weights 0x00010000, bias 0, four contiguous beats -> data_out 0x02000000, ovf 0, valid_out 9 edges after beat 3.
REQ-028 SHALL cover: data 0x00010000, weights 0xFFFF0000, bias 0 -> 0xFE000000 without FC_RELU_EN; 0x00000000 with it.
REQ-029 SHALL cover: data and weights all 0x7FFFFFFF -> data_out 0x7FFFFFFF, ovf 1.
REQ-030 SHALL cover: case REQ-027 with bias 0x00008000 and 3 idle cycles between beats -> 0x02008000, single valid_out pulse.
REQ-031 SHALL cover: rst_n pulsed after beat 2, then a full REQ-027 vector -> exactly one valid_out, value 0x02000000.
REQ-032 SHALL cover: eight contiguous beats (vector A per REQ-027, vector B weights 0x00020000) -> two valid_out pulses 4 cycles apart, values 0x02000000 then 0x04000000.
